// File: rtl/cv32e40x_pkg.sv
// cv32e40x_pkg: pipeline and illegal-instruction event types shared by the capture stage.
package cv32e40x_pkg;

    typedef struct packed {
        logic        instr_valid;
        logic        illegal_insn;
        logic [31:0] pc;
    } ex_wb_pipe_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  hartid;
        logic [31:0] cycle;
    } illegal_evt_t;

    localparam int ILLEGAL_EVT_W = $bits(illegal_evt_t);

endpackage

// File: rtl/cv32e40x_evt_fifo.sv
// cv32e40x_evt_fifo: circular-buffer FIFO with occupancy count and synchronous clear.
module cv32e40x_evt_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop, flush;

    assign flush   = rst_i || clear_i;
    assign full_o  = level_q == LW'(DEPTH);
    assign empty_o = level_q == '0;
    assign do_pop  = pop_i && !empty_o;
    // a full FIFO still takes a push when the head leaves in the same cycle
    assign do_push = push_i && (!full_o || do_pop);
    assign wptr_d  = flush ? '0 : do_push ? wptr_q + 1'b1 : wptr_q;
    assign rptr_d  = flush ? '0 : do_pop ? rptr_q + 1'b1 : rptr_q;
    assign level_d = flush ? '0 : level_q + LW'(do_push) - LW'(do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk_i) begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        level_q <= level_d;
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/cv32e40x_illegal_evt_fifo.sv
// cv32e40x_illegal_evt_fifo: captures illegal instructions reaching WB into a drainable
// event FIFO with a cycle stamp, a saturating drop counter and a sticky overflow flag.
module cv32e40x_illegal_evt_fifo
    import cv32e40x_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  ex_wb_pipe_t              ex_wb_pipe_i,
    input  logic [31:0]              mhartid_i,
    input  logic                     clear_i,
    output logic                     evt_valid_o,
    input  logic                     evt_ready_i,
    output logic [31:0]              evt_pc_o,
    output logic [3:0]               evt_hartid_o,
    output logic [31:0]              evt_cycle_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [CNT_WIDTH-1:0]     drop_cnt_o,
    output logic                     overflow_o
);

    logic [31:0]          cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                 overflow_q, overflow_d;
    logic                 push, pop, full, empty, drop;
    logic                 unused_hartid;
    illegal_evt_t         wr_evt, rd_evt;

    assign push          = ex_wb_pipe_i.instr_valid && ex_wb_pipe_i.illegal_insn;
    assign pop           = evt_valid_o && evt_ready_i;
    assign drop          = push && full && !pop;
    assign wr_evt        = '{pc: ex_wb_pipe_i.pc, hartid: mhartid_i[3:0], cycle: cycle_q};
    assign unused_hartid = ^mhartid_i[31:4];

    cv32e40x_evt_fifo #(
        .WIDTH (ILLEGAL_EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_evt),
        .rdata_o (rd_evt),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

    // cycle stamp keeps running through clear so stamps stay comparable across flushes
    assign cycle_d    = cycle_q + 32'd1;
    assign drop_cnt_d = clear_i ? '0 : (drop && !(&drop_cnt_q)) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    assign overflow_d = !clear_i && (overflow_q || drop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_q    <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            cycle_q    <= cycle_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign evt_valid_o  = !empty;
    assign evt_pc_o     = rd_evt.pc;
    assign evt_hartid_o = rd_evt.hartid;
    assign evt_cycle_o  = rd_evt.cycle;
    assign drop_cnt_o   = drop_cnt_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_cv32e40x_illegal_evt_fifo.sv
// tb_cv32e40x_illegal_evt_fifo: scoreboard bench for the illegal-instruction event FIFO.
module tb_cv32e40x_illegal_evt_fifo;
    import cv32e40x_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_WIDTH = 2;

    logic                   clk = 1'b0;
    logic                   rst_i;
    ex_wb_pipe_t            ex_wb;
    logic [31:0]            mhartid;
    logic                   clear_i;
    logic                   evt_valid_o;
    logic                   evt_ready_i;
    logic [31:0]            evt_pc_o;
    logic [3:0]             evt_hartid_o;
    logic [31:0]            evt_cycle_o;
    logic [$clog2(DEPTH):0] level_o;
    logic [CNT_WIDTH-1:0]   drop_cnt_o;
    logic                   overflow_o;

    int           total = 0;
    int           bad = 0;
    logic [31:0]  tb_cycle = '0;
    illegal_evt_t sb[$];
    illegal_evt_t mon_exp;

    always #5 clk = ~clk;

    cv32e40x_illegal_evt_fifo #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .ex_wb_pipe_i (ex_wb),
        .mhartid_i    (mhartid),
        .clear_i      (clear_i),
        .evt_valid_o  (evt_valid_o),
        .evt_ready_i  (evt_ready_i),
        .evt_pc_o     (evt_pc_o),
        .evt_hartid_o (evt_hartid_o),
        .evt_cycle_o  (evt_cycle_o),
        .level_o      (level_o),
        .drop_cnt_o   (drop_cnt_o),
        .overflow_o   (overflow_o)
    );

    // independent cycle reference: restarts at 0 on reset, free-runs otherwise
    always @(posedge clk) tb_cycle <= rst_i ? 32'd0 : tb_cycle + 32'd1;

    // pops happen at the coming edge; inputs were settled at posedge+2
    always @(negedge clk) begin
        if (!rst_i && !clear_i && evt_valid_o && evt_ready_i) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected got pc=%h want no event", evt_pc_o);
            end else begin
                mon_exp = sb.pop_front();
                if ({evt_pc_o, evt_hartid_o, evt_cycle_o} !== mon_exp) begin
                    bad++;
                    $display("FAIL pop_payload got pc=%h hart=%h cyc=%h want pc=%h hart=%h cyc=%h",
                             evt_pc_o, evt_hartid_o, evt_cycle_o, mon_exp.pc, mon_exp.hartid, mon_exp.cycle);
                end
            end
        end
    end

    task automatic cyc(input logic iv, input logic il, input logic [31:0] pc, input logic [3:0] hart,
                       input logic rdy, input logic clr, input logic rs);
        ex_wb.instr_valid  = iv;
        ex_wb.illegal_insn = il;
        ex_wb.pc           = pc;
        mhartid            = {28'h5A5A5A5, hart};
        evt_ready_i        = rdy;
        clear_i            = clr;
        rst_i              = rs;
        if (rs || clr) sb.delete();
        else if (iv && il && (sb.size() < DEPTH || (rdy && sb.size() > 0)))
            sb.push_back('{pc: pc, hartid: hart, cycle: tb_cycle});
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        cyc(1, 1, 32'h40, 4'h1, 0, 0, 1);
        cyc(1, 1, 32'h44, 4'h1, 0, 0, 1);
        total++; if (evt_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", evt_valid_o); end
        total++; if (level_o !== '0) begin bad++; $display("FAIL reset_level got=%0d want=0", level_o); end
        total++; if (drop_cnt_o !== '0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_cnt_o); end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0h want=0", overflow_o); end
        total++; if ({evt_pc_o, evt_hartid_o, evt_cycle_o} !== '0) begin
            bad++; $display("FAIL reset_payload got pc=%h hart=%h cyc=%h want all zero", evt_pc_o, evt_hartid_o, evt_cycle_o);
        end
    endtask

    task automatic test_single();
        logic [31:0] exp_cyc;
        exp_cyc = tb_cycle;
        cyc(1, 1, 32'h0000_1000, 4'h3, 1, 0, 0);
        total++; if (evt_valid_o !== 1'b1) begin bad++; $display("FAIL single_valid got=%0h want=1", evt_valid_o); end
        total++; if (evt_pc_o !== 32'h1000) begin bad++; $display("FAIL single_pc got=%h want=00001000", evt_pc_o); end
        total++; if (evt_hartid_o !== 4'h3) begin bad++; $display("FAIL single_hart got=%h want=3", evt_hartid_o); end
        total++; if (evt_cycle_o !== exp_cyc) begin bad++; $display("FAIL single_cycle got=%h want=%h", evt_cycle_o, exp_cyc); end
        total++; if (level_o !== 3'd1) begin bad++; $display("FAIL single_level1 got=%0d want=1", level_o); end
        cyc(0, 0, 32'h0, 4'h0, 1, 0, 0);
        total++; if (level_o !== 3'd0) begin bad++; $display("FAIL single_level0 got=%0d want=0", level_o); end
        total++; if (evt_valid_o !== 1'b0) begin bad++; $display("FAIL single_drained got=%0h want=0", evt_valid_o); end
    endtask

    task automatic test_non_illegal();
        for (int i = 0; i < 100; i++) begin
            cyc(1, 0, 32'h2000 + 32'(i * 4), 4'(i), 1, 0, 0);
            total++; if (evt_valid_o !== 1'b0 || level_o !== '0) begin
                bad++; $display("FAIL non_illegal[%0d] got valid=%0h level=%0d want valid=0 level=0", i, evt_valid_o, level_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 32'h500 + 32'(i * 4), 4'(i + 2), 1, 0, 0);
            total++; if (level_o !== 3'd1 || evt_pc_o !== 32'h500 + 32'(i * 4)) begin
                bad++; $display("FAIL b2b[%0d] got level=%0d pc=%h want level=1 pc=%h", i, level_o, evt_pc_o, 32'h500 + 32'(i * 4));
            end
        end
        cyc(0, 0, 32'h0, 4'h0, 1, 0, 0);
        total++; if (level_o !== 3'd0) begin bad++; $display("FAIL b2b_end_level got=%0d want=0", level_o); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) cyc(1, 1, 32'h100 + 32'(i * 4), 4'(i), 0, 0, 0);
        total++; if (level_o !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d want=4", level_o); end
        total++; if (drop_cnt_o !== 2'd2) begin bad++; $display("FAIL ovf_drop got=%0d want=2", drop_cnt_o); end
        total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0h want=1", overflow_o); end
        total++; if (evt_pc_o !== 32'h100) begin bad++; $display("FAIL ovf_stall_head got=%h want=00000100", evt_pc_o); end
        for (int i = 0; i < 4; i++) cyc(0, 0, 32'h0, 4'h0, 1, 0, 0);
        total++; if (level_o !== 3'd0 || sb.size() != 0) begin
            bad++; $display("FAIL ovf_drain got level=%0d left=%0d want level=0 left=0", level_o, sb.size());
        end
    endtask

    task automatic test_full_push_pop();
        cyc(0, 0, 32'h0, 4'h0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 32'h300 + 32'(i * 4), 4'h7, 0, 0, 0);
        total++; if (level_o !== 3'd4) begin bad++; $display("FAIL fpp_fill got=%0d want=4", level_o); end
        cyc(1, 1, 32'h200, 4'h9, 1, 0, 0);
        total++; if (level_o !== 3'd4) begin bad++; $display("FAIL fpp_level got=%0d want=4", level_o); end
        total++; if (drop_cnt_o !== 2'd0 || overflow_o !== 1'b0) begin
            bad++; $display("FAIL fpp_drop got drop=%0d ovf=%0h want drop=0 ovf=0", drop_cnt_o, overflow_o);
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 32'h0, 4'h0, 1, 0, 0);
        total++; if (level_o !== 3'd0 || sb.size() != 0) begin
            bad++; $display("FAIL fpp_drain got level=%0d left=%0d want level=0 left=0", level_o, sb.size());
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 6; i++) cyc(1, 1, 32'h600 + 32'(i * 4), 4'h1, 0, 0, 0);
        total++; if (drop_cnt_o !== 2'd2) begin bad++; $display("FAIL sat_two got=%0d want=2", drop_cnt_o); end
        for (int i = 0; i < 3; i++) cyc(1, 1, 32'h700 + 32'(i * 4), 4'h1, 0, 0, 0);
        total++; if (drop_cnt_o !== 2'd3) begin bad++; $display("FAIL sat_max got=%0d want=3", drop_cnt_o); end
        cyc(0, 0, 32'h0, 4'h0, 1, 0, 0);
        total++; if (level_o !== 3'd3 || overflow_o !== 1'b1) begin
            bad++; $display("FAIL sat_pop got level=%0d ovf=%0h want level=3 ovf=1", level_o, overflow_o);
        end
    endtask

    task automatic test_clear();
        cyc(1, 1, 32'h800, 4'h2, 0, 1, 0);
        total++; if (level_o !== 3'd0 || evt_valid_o !== 1'b0) begin
            bad++; $display("FAIL clr_level got level=%0d valid=%0h want level=0 valid=0", level_o, evt_valid_o);
        end
        total++; if (overflow_o !== 1'b0 || drop_cnt_o !== 2'd0) begin
            bad++; $display("FAIL clr_flags got ovf=%0h drop=%0d want ovf=0 drop=0", overflow_o, drop_cnt_o);
        end
        cyc(0, 0, 32'h0, 4'h0, 0, 0, 0);
        total++; if (evt_valid_o !== 1'b0) begin bad++; $display("FAIL clr_push_discard got=%0h want=0", evt_valid_o); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) cyc(1, 1, 32'h900 + 32'(i * 4), 4'h5, 0, 0, 0);
        total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL rst_pre_ovf got=%0h want=1", overflow_o); end
        cyc(1, 1, 32'hA00, 4'h6, 0, 0, 1);
        total++; if (level_o !== 3'd0 || evt_valid_o !== 1'b0 || overflow_o !== 1'b0 || drop_cnt_o !== 2'd0) begin
            bad++; $display("FAIL rst_mid got level=%0d valid=%0h ovf=%0h drop=%0d want all 0", level_o, evt_valid_o, overflow_o, drop_cnt_o);
        end
        cyc(1, 1, 32'hB00, 4'hC, 0, 0, 0);
        total++; if (evt_valid_o !== 1'b1 || evt_cycle_o !== 32'd0) begin
            bad++; $display("FAIL rst_cycle_restart got valid=%0h cyc=%h want valid=1 cyc=00000000", evt_valid_o, evt_cycle_o);
        end
        cyc(0, 0, 32'h0, 4'h0, 1, 0, 0);
        total++; if (level_o !== 3'd0) begin bad++; $display("FAIL rst_drain got=%0d want=0", level_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1'b1;
        clear_i = 1'b0;
        evt_ready_i = 1'b0;
        ex_wb = '0;
        mhartid = '0;
        @(posedge clk);
        #2;
        test_reset();
        test_single();
        test_non_illegal();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_saturation();
        test_clear();
        test_reset_mid();
        total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cv32e40x_illegal_evt_fifo.md
# cv32e40x_illegal_evt_fifo

Event capture stage that sits directly downstream of the EX/WB pipeline register, alongside the simulation logger. It records every illegal instruction reaching WB (PC, hart ID, cycle stamp) into a small FIFO. The FIFO drains over a valid/ready port to a debug/trace sink, which makes the events usable in synthesized builds without `$display`. Overflow is counted, never silently lost.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- CNT_WIDTH, 8: width of the saturating drop counter.
- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- ex_wb_pipe_i  in  ex_wb_pipe_t  EX/WB pipe; uses .instr_valid, .illegal_insn, .pc.
- mhartid_i  in  32  hart ID; bits [3:0] are stored.
- clear_i  in  1  synchronous flush of FIFO, drop counter and sticky flags.
- evt_valid_o  out  1  head entry valid.
- evt_ready_i  in  1  sink accepts head entry.
- evt_pc_o  out  32  head entry PC.
- evt_hartid_o  out  4  head entry hart ID.
- evt_cycle_o  out  32  head entry cycle stamp.
- level_o  out  $clog2(DEPTH)+1  current occupancy.
- drop_cnt_o  out  CNT_WIDTH  events lost while full; saturates at all-ones.
- overflow_o  out  1  sticky; set on the first drop.

## Operation
- Push condition: ex_wb_pipe_i.instr_valid && ex_wb_pipe_i.illegal_insn, sampled at the rising edge.
- Pushed entry: {pc, mhartid_i[3:0], cycle_q}. cycle_q is a free-running 32-bit counter that increments every cycle and wraps 0xFFFFFFFF -> 0.
- Pop condition: evt_valid_o && evt_ready_i. The head advances at that edge.
- Storage: circular buffer with $clog2(DEPTH)-bit read and write pointers that wrap at DEPTH-1 -> 0, plus an occupancy counter.
- Full (level==DEPTH), push, no pop: entry discarded; drop_cnt increments unless saturated; overflow set.
- Full, push and pop in the same cycle: push accepted, level unchanged, no drop.
- Empty, push and pop in the same cycle: cannot occur, because evt_valid_o is 0 when empty. No bypass path.
- clear_i: pointers, level, drop_cnt and overflow go to 0 at the edge. cycle_q is not cleared. A push in the same cycle as clear_i is discarded.
- Sink stall: evt_pc_o, evt_hartid_o and evt_cycle_o stay stable while evt_valid_o && !evt_ready_i.
- Reset values: evt_valid_o=0, level_o=0, drop_cnt_o=0, overflow_o=0, cycle_q=0. Entry payload outputs are don't-care while invalid, but drive 0 after reset.

## Timing
- Push to evt_valid_o: 1 cycle. The event sampled at edge N is visible after edge N.
- Pop to next head: 1 cycle. Back-to-back pops sustain 1 event/cycle.
- level_o and drop_cnt_o are registered and reflect the edge's push/pop result immediately after it.
- Reset asserted mid-operation: all entries discarded at the next edge, and outputs show reset values after that edge.
- Reset takes priority over clear_i. clear_i takes priority over push and pop.

## Structure
- New typedef illegal_evt_t {pc[31:0], hartid[3:0], cycle[31:0]} goes into cv32e40x_pkg, next to ex_wb_pipe_t.
- The FIFO core is a natural sub-module, cv32e40x_evt_fifo (parameterised width/depth, push/pop/full/empty/level, synchronous clear).
- The top level adds the push qualifier, cycle counter, drop counter and sticky flag.
- No combinational path from evt_ready_i to any output other than through registered state.

## Test plan
- Single event: illegal at PC 0x0000_1000, hart 3, ready=1 -> one cycle later evt_valid_o=1, evt_pc_o=0x1000, evt_hartid_o=3, evt_cycle_o equals the cycle of capture; level returns to 0 after the pop.
- Non-illegal traffic: instr_valid=1 with illegal_insn=0 for 100 cycles -> evt_valid_o stays 0, level_o=0.
- Overflow, DEPTH=4, ready=0: 6 illegal events at PCs 0x100..0x114 -> level_o=4, drop_cnt_o=2, overflow_o=1; draining yields 0x100, 0x104, 0x108, 0x10C in order.
- Full with simultaneous push/pop: level=4, push 0x200 with ready=1 -> level stays 4, drop_cnt unchanged, 0x200 emerges last.
- Saturation, CNT_WIDTH=2: 5 drops -> drop_cnt_o=3.
- Clear and reset mid-stream: 3 entries then clear_i=1 with a concurrent push -> level_o=0, evt_valid_o=0, overflow_o=0. Repeat with rst_i=1 -> same result, and cycle_q restarts at 0.
